// File: rtl/ones_comp_pkg.sv
// Shared types and one's-complement helpers for the sequential divider.
package ones_comp_pkg;
    localparam int NUM_BIT = 15;

    typedef logic [NUM_BIT-1:0]   word_t;
    typedef logic [2*NUM_BIT-1:0] dword_t;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} div_state_e;

    function automatic word_t oc_neg(input word_t x);
        return ~x;
    endfunction

    function automatic word_t oc_abs(input word_t x);
        return x[NUM_BIT-1] ? ~x : x;
    endfunction

    // Both +0 and -0 count as zero in one's complement.
    function automatic logic oc_is_zero(input word_t x);
        return (x == '0) || (x == '1);
    endfunction
endpackage

// File: rtl/ones_comp_div_step.sv
// One combinational restoring-division step on magnitudes.
module ones_comp_div_step #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH-2:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-2:0] dmag,
    output logic [WIDTH-2:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] diff;

    assign trial   = {rem_in, bit_in};
    assign diff    = trial - {1'b0, dmag};
    assign q_bit   = trial >= {1'b0, dmag};
    // With q_bit clear, trial < dmag so its top bit is zero and it still fits.
    assign rem_out = q_bit ? diff[WIDTH-2:0] : trial[WIDTH-2:0];
endmodule

// File: rtl/ones_comp_seq_div.sv
// Multi-cycle one's-complement divider (2W/W -> W quotient and remainder).
// Define ONES_COMP_DIV_RADIX4_EN to retire two quotient bits per iteration cycle.
module ones_comp_seq_div
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = NUM_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [2*WIDTH-1:0] numer,
    input  logic [WIDTH-1:0]   denom,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   remain,
    output logic               overflow_flag,
    output logic               div_zero_flag
);
    localparam int MW = WIDTH - 1;
`ifdef ONES_COMP_DIV_RADIX4_EN
    localparam int BITS_PER_CYC = 2;
`else
    localparam int BITS_PER_CYC = 1;
`endif
    localparam int ITER_CYC = MW / BITS_PER_CYC;
    localparam int CNT_W    = $clog2(ITER_CYC + 1);
    localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {MW{1'b1}}};

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] numer_r;
    logic [WIDTH-1:0]   denom_r;
    logic [MW-1:0]      dmag_r, rem_r, lo_r, qmag_r;
    logic [MW-1:0]      rem_next, lo_next, qmag_next;
    logic [2*WIDTH-2:0] nmag;
    logic [WIDTH-1:0]   dabs;
    logic               sn, sd, dzero, ovf;

    assign sn    = numer_r[2*WIDTH-1];
    assign sd    = denom_r[WIDTH-1];
    assign nmag  = sn ? ~numer_r[2*WIDTH-2:0] : numer_r[2*WIDTH-2:0];
    assign dabs  = oc_abs(denom_r);
    assign dzero = oc_is_zero(denom_r);
    // Upper half >= divisor means the quotient needs more than WIDTH-1 bits.
    assign ovf   = nmag[2*WIDTH-2:MW] >= dabs;

`ifdef ONES_COMP_DIV_RADIX4_EN
    if ((MW % 2) != 0) begin : g_width_check
        $error("ones_comp_seq_div: radix-4 needs WIDTH-1 even");
    end

    logic [MW-1:0] rem_mid;
    logic          q_hi, q_lo;

    ones_comp_div_step #(.WIDTH(WIDTH)) u_step_hi (
        .rem_in(rem_r), .bit_in(lo_r[MW-1]), .dmag(dmag_r), .rem_out(rem_mid), .q_bit(q_hi)
    );
    ones_comp_div_step #(.WIDTH(WIDTH)) u_step_lo (
        .rem_in(rem_mid), .bit_in(lo_r[MW-2]), .dmag(dmag_r), .rem_out(rem_next), .q_bit(q_lo)
    );
    assign lo_next   = lo_r << 2;
    assign qmag_next = {qmag_r[MW-3:0], q_hi, q_lo};
`else
    logic q_b;

    ones_comp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in(rem_r), .bit_in(lo_r[MW-1]), .dmag(dmag_r), .rem_out(rem_next), .q_bit(q_b)
    );
    assign lo_next   = lo_r << 1;
    assign qmag_next = {qmag_r[MW-2:0], q_b};
`endif

    // Datapath: operand capture, magnitude setup, iteration
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start_valid && start_ready) begin
                numer_r <= numer;
                denom_r <= denom;
            end
            PREP: begin
                dmag_r <= dabs[MW-1:0];
                rem_r  <= nmag[2*WIDTH-3:MW];
                lo_r   <= nmag[MW-1:0];
                qmag_r <= '0;
            end
            ITER: begin
                rem_r  <= rem_next;
                lo_r   <= lo_next;
                qmag_r <= qmag_next;
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            start_ready   <= 1'b1;
            res_valid     <= 1'b0;
            quot          <= '0;
            remain        <= '0;
            overflow_flag <= 1'b0;
            div_zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    state       <= PREP;
                    start_ready <= 1'b0;
                end
                PREP: begin
                    cnt <= '0;
                    if (dzero || ovf) begin
                        quot          <= (sn ^ sd) ? oc_neg(MAX_MAG) : MAX_MAG;
                        remain        <= sn ? '1 : '0;
                        div_zero_flag <= dzero;
                        overflow_flag <= !dzero;
                        state         <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER_CYC - 1)) state <= FIX;
                end
                FIX: begin
                    quot          <= (sn ^ sd) ? oc_neg({1'b0, qmag_r}) : {1'b0, qmag_r};
                    remain        <= sn ? oc_neg({1'b0, rem_r}) : {1'b0, rem_r};
                    div_zero_flag <= 1'b0;
                    overflow_flag <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
